// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-stage status in, stage-register controls out.
// The pipeline drives the master side and the hazard controller sits on the slave side.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_jump;
  logic             ex_valid;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_memread;
  logic             ex_mul;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;

  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_hold;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             ifid_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_jump,
           ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_mul,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  pc_hold, ifid_hold, idex_hold, idex_bubble, exmem_bubble,
           ifid_flush, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_jump,
           ex_valid, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread, ex_mul,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output pc_hold, ifid_hold, idex_hold, idex_bubble, exmem_bubble,
           ifid_flush, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Define FORWARDING_EN to enable EX operand forwarding (RAW stalls then only on load-use).
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  // A multiply holds for MUL_LAT-1 cycles: the entry cycle in RUN plus MUL_LAT-2
  // cycles of MUL_WAIT, so the wait counter is loaded one lower and exits at 0.
  localparam bit         HAS_MUL_HOLD  = (MUL_LAT > 1);
  localparam bit         HAS_MUL_WAIT  = (MUL_LAT > 2);
  localparam logic [3:0] MUL_WAIT_LOAD = HAS_MUL_WAIT ? 4'(MUL_LAT - 3) : 4'd0;

  state_t           state_q, state_d;
  logic [3:0]       mul_cnt_q, mul_cnt_d;
  logic             mul_done_q, mul_done_d;
  logic             flushed_q, flushed_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             mul_start;
  logic             mul_hold;
  logic             raw_hazard;
  logic             raw_stall;
  logic             hold;
  logic             flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input logic [4:0] dst, input logic dst_we);
    return use_src & (src == dst) & dst_we;
  endfunction

`ifdef FORWARDING_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd == src)) return 2'b01;
    if (w_we && (w_rd == src)) return 2'b10;
    return 2'b00;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mul_cnt_q   <= '0;
      mul_done_q  <= 1'b0;
      flushed_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      mul_done_q  <= mul_done_d;
      flushed_q   <= flushed_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;
    mul_done_d = 1'b0;
    mul_hold   = 1'b0;
    // mul_done_q masks the release cycle, when the finished MUL still sits in IdEx
    mul_start  = HAS_MUL_HOLD && (state_q == RUN) && bus.ex_valid && bus.ex_mul && !mul_done_q;

    unique case (state_q)
      RUN: begin
        if (mul_start) begin
          mul_hold = 1'b1;
          if (HAS_MUL_WAIT) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = MUL_WAIT_LOAD;
          end else begin
            mul_done_d = 1'b1;
          end
        end
      end
      MUL_WAIT: begin
        mul_hold = 1'b1;
        if (mul_cnt_q == '0) begin
          state_d    = RUN;
          mul_done_d = 1'b1;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase

`ifdef FORWARDING_EN
    raw_hazard = bus.id_valid &
                 (src_hit(bus.id_use_rs, bus.id_rs, bus.ex_rd,
                          bus.ex_valid & bus.ex_memread & bus.ex_regwrite) |
                  src_hit(bus.id_use_rt, bus.id_rt, bus.ex_rd,
                          bus.ex_valid & bus.ex_memread & bus.ex_regwrite));
`else
    raw_hazard = bus.id_valid &
                 (src_hit(bus.id_use_rs, bus.id_rs, bus.ex_rd, bus.ex_valid & bus.ex_regwrite) |
                  src_hit(bus.id_use_rs, bus.id_rs, bus.mem_rd, bus.mem_regwrite) |
                  src_hit(bus.id_use_rs, bus.id_rs, bus.wb_rd, bus.wb_regwrite) |
                  src_hit(bus.id_use_rt, bus.id_rt, bus.ex_rd, bus.ex_valid & bus.ex_regwrite) |
                  src_hit(bus.id_use_rt, bus.id_rt, bus.mem_rd, bus.mem_regwrite) |
                  src_hit(bus.id_use_rt, bus.id_rt, bus.wb_rd, bus.wb_regwrite));
`endif

    raw_stall = raw_hazard & ~mul_hold;
    hold      = mul_hold | raw_stall;
    // A held jump flushes once on release; the slot after a flush is already a NOP
    flush     = ~hold & bus.id_valid & bus.id_jump & ~flushed_q;
    flushed_d = flush;

    stall_cnt_d = stall_cnt_q;
    if (hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end

    fwd_a = '0;
    fwd_b = '0;
`ifdef FORWARDING_EN
    if (!mul_hold) begin
      fwd_a = fwd_sel(bus.ex_rs, bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
      fwd_b = fwd_sel(bus.ex_rt, bus.mem_rd, bus.mem_regwrite, bus.wb_rd, bus.wb_regwrite);
    end
`endif

    bus.pc_hold      = ~reset & hold;
    bus.ifid_hold    = ~reset & hold;
    bus.idex_hold    = ~reset & mul_hold;
    bus.idex_bubble  = ~reset & raw_stall;
    bus.exmem_bubble = ~reset & mul_hold;
    bus.ifid_flush   = ~reset & flush;
    bus.fwd_a        = reset ? 2'b00 : fwd_a;
    bus.fwd_b        = reset ? 2'b00 : fwd_b;
    bus.stall_cnt    = reset ? '0 : stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus against a cycle-occupancy reference model; two counter widths.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned MUL_LAT = 4;
  localparam logic [9:0] HOLD_RAW = 10'b1101000000;
  localparam logic [9:0] HOLD_MUL = 10'b1110100000;
  localparam logic [9:0] FLUSH    = 10'b0000010000;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_occ = 0;
  bit   m_flushed = 1'b0;
  int   m_cnt = 0;
  int   m_cnt2 = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) u_if ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  u_if2 ();

  assign u_if2.id_valid     = u_if.id_valid;
  assign u_if2.id_rs        = u_if.id_rs;
  assign u_if2.id_rt        = u_if.id_rt;
  assign u_if2.id_use_rs    = u_if.id_use_rs;
  assign u_if2.id_use_rt    = u_if.id_use_rt;
  assign u_if2.id_jump      = u_if.id_jump;
  assign u_if2.ex_valid     = u_if.ex_valid;
  assign u_if2.ex_rs        = u_if.ex_rs;
  assign u_if2.ex_rt        = u_if.ex_rt;
  assign u_if2.ex_rd        = u_if.ex_rd;
  assign u_if2.ex_regwrite  = u_if.ex_regwrite;
  assign u_if2.ex_memread   = u_if.ex_memread;
  assign u_if2.ex_mul       = u_if.ex_mul;
  assign u_if2.mem_rd       = u_if.mem_rd;
  assign u_if2.mem_regwrite = u_if.mem_regwrite;
  assign u_if2.wb_rd        = u_if.wb_rd;
  assign u_if2.wb_regwrite  = u_if.wb_regwrite;

  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(u_if.slave));
  pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(u_if2.slave));

  always #5 clk = ~clk;

  function automatic logic [9:0] got();
    return {u_if.pc_hold, u_if.ifid_hold, u_if.idex_hold, u_if.idex_bubble,
            u_if.exmem_bubble, u_if.ifid_flush, u_if.fwd_a, u_if.fwd_b};
  endfunction

  // ---------------- reference model ----------------
  // A multiply occupies EX for MUL_LAT cycles; all but the last of them hold the pipe.
  function automatic int model_occ();
    if (m_occ == 0 && u_if.ex_valid && u_if.ex_mul) return MUL_LAT;
    return m_occ;
  endfunction

  function automatic bit id_reads(input logic [4:0] r);
    return (u_if.id_use_rs && u_if.id_rs == r) || (u_if.id_use_rt && u_if.id_rt == r);
  endfunction

  function automatic bit model_raw();
`ifdef FORWARDING_EN
    return u_if.id_valid && u_if.ex_valid && u_if.ex_memread && u_if.ex_regwrite &&
           id_reads(u_if.ex_rd);
`else
    logic [4:0] dst [3];
    bit         we  [3];
    dst[0] = u_if.ex_rd;  we[0] = u_if.ex_valid && u_if.ex_regwrite;
    dst[1] = u_if.mem_rd; we[1] = u_if.mem_regwrite;
    dst[2] = u_if.wb_rd;  we[2] = u_if.wb_regwrite;
    for (int k = 0; k < 3; k++)
      if (we[k] && id_reads(dst[k])) return u_if.id_valid;
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef FORWARDING_EN
    if (u_if.mem_regwrite && u_if.mem_rd == src) return 2'b01;
    if (u_if.wb_regwrite && u_if.wb_rd == src) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic logic [9:0] model_out();
    bit mh, rs, hd, fl;
    logic [1:0] fa, fb;
    if (reset) return '0;
    mh = model_occ() > 1;
    rs = !mh && model_raw();
    hd = mh || rs;
    fl = !hd && u_if.id_valid && u_if.id_jump && !m_flushed;
    fa = mh ? 2'b00 : model_fwd(u_if.ex_rs);
    fb = mh ? 2'b00 : model_fwd(u_if.ex_rt);
    return {hd, hd, mh, rs, mh, fl, fa, fb};
  endfunction

  task automatic tick();
    logic [9:0] e;
    int occ;
    e = model_out();
    if (reset) begin
      m_occ = 0; m_flushed = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      occ = model_occ();
      m_occ = (occ > 0) ? occ - 1 : 0;
      m_flushed = e[4];
      if (e[9]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    u_if.id_valid = 0; u_if.id_rs = 0; u_if.id_rt = 0; u_if.id_use_rs = 0;
    u_if.id_use_rt = 0; u_if.id_jump = 0; u_if.ex_valid = 0; u_if.ex_rs = 0;
    u_if.ex_rt = 0; u_if.ex_rd = 0; u_if.ex_regwrite = 0; u_if.ex_memread = 0;
    u_if.ex_mul = 0; u_if.mem_rd = 0; u_if.mem_regwrite = 0; u_if.wb_rd = 0;
    u_if.wb_regwrite = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    set_idle();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    u_if.id_valid = 1; u_if.id_rs = '1; u_if.id_rt = '1; u_if.id_use_rs = 1;
    u_if.id_use_rt = 1; u_if.id_jump = 1; u_if.ex_valid = 1; u_if.ex_rs = '1;
    u_if.ex_rt = '1; u_if.ex_rd = '1; u_if.ex_regwrite = 1; u_if.ex_memread = 1;
    u_if.ex_mul = 1; u_if.mem_rd = '1; u_if.mem_regwrite = 1; u_if.wb_rd = '1;
    u_if.wb_regwrite = 1;
    @(negedge clk);
    n_cmp++;
    if (got() !== 10'b0 || u_if.stall_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_all_ones: outputs %b cnt %0d, expected 0 / 0", got(), u_if.stall_cnt);
    end
    tick();
    reset = 1'b0;
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (got() !== 10'b0 || u_if.stall_cnt !== 16'd0 || u_if2.stall_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL first_cycle_idle: outputs %b cnt %0d, expected 0 / 0", got(), u_if.stall_cnt);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [9:0] exp2, exp3;
`ifdef FORWARDING_EN
    exp2 = 10'b0; exp3 = 10'b0000001000;
`else
    exp2 = HOLD_RAW; exp3 = 10'b0;
`endif
    apply_reset();
    u_if.id_valid = 1; u_if.id_rs = 5; u_if.id_use_rs = 1;
    u_if.ex_valid = 1; u_if.ex_rd = 5; u_if.ex_regwrite = 1; u_if.ex_memread = 1;
    @(negedge clk);
    n_cmp++;
    if (got() !== HOLD_RAW) begin
      n_bad++; $display("FAIL load_use_stall: got %b expected %b", got(), HOLD_RAW);
    end
    tick();
    u_if.ex_valid = 0; u_if.ex_regwrite = 0; u_if.ex_memread = 0;
    u_if.mem_rd = 5; u_if.mem_regwrite = 1;
    @(negedge clk);
    n_cmp++;
    if (u_if.stall_cnt !== 16'd1 || got() !== exp2) begin
      n_bad++;
      $display("FAIL load_use_after: cnt %0d out %b expected 1 / %b", u_if.stall_cnt, got(), exp2);
    end
    tick();
    u_if.id_valid = 0; u_if.ex_valid = 1; u_if.ex_rs = 5; u_if.ex_rd = 9;
    u_if.ex_regwrite = 1; u_if.mem_regwrite = 0; u_if.wb_rd = 5; u_if.wb_regwrite = 1;
    @(negedge clk);
    n_cmp++;
    if (got() !== exp3) begin
      n_bad++; $display("FAIL load_use_wb_fwd: got %b expected %b", got(), exp3);
    end
    tick();
  endtask

  task automatic test_forward();
    logic [9:0] exp [3];
`ifdef FORWARDING_EN
    exp[0] = 10'b0000000100; exp[1] = 10'b0000001000; exp[2] = 10'b0000001010;
`else
    exp[0] = 10'b0; exp[1] = 10'b0; exp[2] = 10'b0;
`endif
    apply_reset();
    u_if.ex_valid = 1; u_if.ex_rs = 3; u_if.ex_rt = 0; u_if.ex_rd = 12;
    u_if.mem_rd = 3; u_if.wb_rd = 3; u_if.mem_regwrite = 1; u_if.wb_regwrite = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) u_if.mem_regwrite = 0;
      if (i == 2) u_if.ex_rt = 3;
      @(negedge clk);
      n_cmp++;
      if (got() !== exp[i]) begin
        n_bad++; $display("FAIL forward_%0d: got %b expected %b", i, got(), exp[i]);
      end
      tick();
    end
    u_if.ex_mul = 1;
    @(negedge clk);
    n_cmp++;
    if (got() !== HOLD_MUL) begin
      n_bad++; $display("FAIL forward_during_hold: got %b expected %b", got(), HOLD_MUL);
    end
    tick();
  endtask

  task automatic test_mul();
    logic [9:0] e;
    apply_reset();
    u_if.ex_valid = 1; u_if.ex_mul = 1;
    for (int i = 0; i < MUL_LAT; i++) begin
      e = (i < MUL_LAT - 1) ? HOLD_MUL : 10'b0;
      @(negedge clk);
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL mul_cycle_%0d: got %b expected %b", i, got(), e);
      end
      tick();
    end
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (got() !== 10'b0 || u_if.stall_cnt !== 16'(MUL_LAT - 1)) begin
      n_bad++;
      $display("FAIL mul_done: out %b cnt %0d expected 0 / %0d", got(), u_if.stall_cnt, MUL_LAT - 1);
    end
    tick();
    // reset arriving in the second hold cycle
    apply_reset();
    u_if.ex_valid = 1; u_if.ex_mul = 1;
    tick();
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (got() !== 10'b0) begin
      n_bad++; $display("FAIL mul_reset_during: got %b expected 0", got());
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (got() !== 10'b0 || u_if.stall_cnt !== 16'd0) begin
      n_bad++; $display("FAIL mul_reset_after: out %b cnt %0d expected 0 / 0", got(), u_if.stall_cnt);
    end
    tick();
  endtask

  task automatic test_jump_during_mul();
    logic [9:0] e;
    apply_reset();
    u_if.ex_valid = 1; u_if.ex_mul = 1; u_if.id_valid = 1; u_if.id_jump = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) u_if.ex_mul = 0;
      if (i == 5) u_if.id_jump = 0;
      e = (i < MUL_LAT - 1) ? HOLD_MUL : (i == MUL_LAT - 1) ? FLUSH : 10'b0;
      @(negedge clk);
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL jump_mul_cycle_%0d: got %b expected %b", i, got(), e);
      end
      tick();
    end
  endtask

  task automatic test_raw_chain();
    logic [9:0] e;
    int exp_cnt;
`ifdef FORWARDING_EN
    e = 10'b0; exp_cnt = 0;
`else
    e = HOLD_RAW; exp_cnt = 3;
`endif
    apply_reset();
    u_if.id_valid = 1; u_if.id_rt = 7; u_if.id_use_rt = 1;
    u_if.ex_valid = 1; u_if.ex_rd = 7; u_if.ex_regwrite = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        u_if.ex_valid = 0; u_if.ex_regwrite = 0; u_if.mem_rd = 7; u_if.mem_regwrite = 1;
      end
      if (i == 2) begin
        u_if.mem_regwrite = 0; u_if.wb_rd = 7; u_if.wb_regwrite = 1;
      end
      @(negedge clk);
      n_cmp++;
      if (got() !== e) begin
        n_bad++; $display("FAIL raw_chain_%0d: got %b expected %b", i, got(), e);
      end
      tick();
    end
    u_if.wb_regwrite = 0;
    @(negedge clk);
    n_cmp++;
    if (got() !== 10'b0 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      n_bad++;
      $display("FAIL raw_chain_end: out %b cnt %0d expected 0 / %0d", got(), u_if.stall_cnt, exp_cnt);
    end
    tick();
  endtask

  task automatic test_saturate();
    apply_reset();
    u_if.id_valid = 1; u_if.id_rs = 2; u_if.id_use_rs = 1;
    u_if.ex_valid = 1; u_if.ex_rd = 2; u_if.ex_regwrite = 1; u_if.ex_memread = 1;
    for (int i = 0; i < 5; i++) tick();
    set_idle();
    @(negedge clk);
    n_cmp++;
    if (u_if2.stall_cnt !== 2'd3 || u_if.stall_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL saturate: cnt2 %0d cnt16 %0d expected 3 / 5", u_if2.stall_cnt, u_if.stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] e;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      u_if.id_valid     = $urandom_range(0, 3) != 0;
      u_if.id_rs        = 5'($urandom_range(0, 3));
      u_if.id_rt        = 5'($urandom_range(0, 3));
      u_if.id_use_rs    = $urandom_range(0, 1) != 0;
      u_if.id_use_rt    = $urandom_range(0, 1) != 0;
      u_if.id_jump      = $urandom_range(0, 3) == 0;
      u_if.ex_valid     = $urandom_range(0, 3) != 0;
      u_if.ex_rs        = 5'($urandom_range(0, 3));
      u_if.ex_rt        = 5'($urandom_range(0, 3));
      u_if.ex_rd        = 5'($urandom_range(0, 3));
      u_if.ex_regwrite  = $urandom_range(0, 1) != 0;
      u_if.ex_memread   = $urandom_range(0, 1) != 0;
      u_if.ex_mul       = $urandom_range(0, 9) == 0;
      u_if.mem_rd       = 5'($urandom_range(0, 3));
      u_if.mem_regwrite = $urandom_range(0, 1) != 0;
      u_if.wb_rd        = 5'($urandom_range(0, 3));
      u_if.wb_regwrite  = $urandom_range(0, 1) != 0;
      @(negedge clk);
      e = model_out();
      n_cmp++;
      if (got() !== e || u_if.stall_cnt !== 16'(reset ? 0 : m_cnt) ||
          u_if2.stall_cnt !== 2'(reset ? 0 : m_cnt2)) begin
        n_bad++;
        $display("FAIL random_%0d: out %b cnt %0d cnt2 %0d expected %b / %0d / %0d",
                 i, got(), u_if.stall_cnt, u_if2.stall_cnt, e,
                 reset ? 0 : m_cnt, reset ? 0 : m_cnt2);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    #1;
    test_reset();
    test_load_use();
    test_forward();
    test_mul();
    test_jump_during_mul();
    test_raw_chain();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
